// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution queue: branch opcodes,
// the branch decode helper and the queued entry layout.
package branch_pkg;

  // {funct3, major opcode} encodings of the two conditional branches
  localparam logic [11:0] OP_BEQ = 12'h063;
  localparam logic [11:0] OP_BNE = 12'h0E3;

  localparam int BR_PC_W = 32;

  typedef struct packed {
    logic               pred;
    logic [BR_PC_W-1:0] alt_pc;
  } br_entry_t;

  function automatic logic is_br(input logic [11:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/branch_entry_fifo.sv
// Circular storage of in-flight branch entries with head/tail/count and a
// single-cycle flush that empties the queue.
module branch_entry_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 33,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [W-1:0]  i_push_data,
  output logic          o_full,
  output logic [CW-1:0] o_count,
  output logic [W-1:0]  o_head_data
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  // Storage is not reset; occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_tail] <= i_push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + AW'(1);
      if (i_pop)  r_head <= r_head + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_full      = (r_count == CW'(DEPTH));
  assign o_count     = r_count;
  assign o_head_data = r_mem[r_head];

endmodule

// File: rtl/branch_resolution_queue.sv
// Tracks conditional branches from decode to commit, flags mispredictions
// combinationally at commit and supplies the fetch redirect PC.
module branch_resolution_queue
  import branch_pkg::*;
#(
  parameter  int DEPTH   = 4,
  parameter  int PC_W    = BR_PC_W,
  parameter  int PC_STEP = 1,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     Decoded_opcode,
  input  logic [PC_W-1:0] Decoded_PC,
  input  logic [PC_W-1:0] Decoded_target,
  input  logic            predicted,
  input  logic [11:0]     Commit_opcode,
  input  logic            Commit_taken,
  output logic            Wrong_prediction,
  output logic [PC_W-1:0] Redirect_PC,
  output logic            Full,
  output logic [CW-1:0]   Count,
  output logic            Underflow_err
);

  logic      w_dec_br;
  logic      w_com_br;
  logic      w_empty;
  logic      w_pop;
  logic      w_push;
  logic      w_mispredict;
  br_entry_t w_new;
  br_entry_t w_head;
  logic      r_underflow;

  assign w_dec_br = is_br(Decoded_opcode);
  assign w_com_br = is_br(Commit_opcode);
  assign w_empty  = (Count == '0);
  assign w_pop    = w_com_br && !w_empty;

  assign w_mispredict = w_pop && (w_head.pred != Commit_taken);

  // A push alongside a mispredict is a younger, squashed branch.
  assign w_push = w_dec_br && (!Full || w_pop) && !w_mispredict;

  always_comb begin
    w_new        = '0;
    w_new.pred   = predicted;
    w_new.alt_pc = predicted ? (Decoded_PC + PC_W'(PC_STEP)) : Decoded_target;
  end

  branch_entry_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(br_entry_t))
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_flush     (w_mispredict),
    .i_push_data (w_new),
    .o_full      (Full),
    .o_count     (Count),
    .o_head_data (w_head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   r_underflow <= 1'b0;
    else if (w_com_br && w_empty) r_underflow <= 1'b1;
  end

  assign Wrong_prediction = w_mispredict;
  assign Redirect_PC      = w_mispredict ? w_head.alt_pc : '0;
  assign Underflow_err    = r_underflow;

endmodule

// File: tb/tb_branch_resolution_queue.sv
// Directed-vector bench: the driver queues hand-computed expectations per
// cycle and a monitor compares them against the DUT mid-cycle.
module tb_branch_resolution_queue;
  import branch_pkg::*;

  localparam logic [11:0] NOP = 12'h013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] Decoded_opcode = NOP;
  logic [31:0] Decoded_PC = '0;
  logic [31:0] Decoded_target = '0;
  logic        predicted = 1'b0;
  logic [11:0] Commit_opcode = NOP;
  logic        Commit_taken = 1'b0;
  logic        Wrong_prediction;
  logic [31:0] Redirect_PC;
  logic        Full;
  logic [2:0]  Count;
  logic        Underflow_err;

  branch_resolution_queue #(.DEPTH(4), .PC_W(32), .PC_STEP(1)) dut (
    .clk              (clk),
    .rst              (rst),
    .Decoded_opcode   (Decoded_opcode),
    .Decoded_PC       (Decoded_PC),
    .Decoded_target   (Decoded_target),
    .predicted        (predicted),
    .Commit_opcode    (Commit_opcode),
    .Commit_taken     (Commit_taken),
    .Wrong_prediction (Wrong_prediction),
    .Redirect_PC      (Redirect_PC),
    .Full             (Full),
    .Count            (Count),
    .Underflow_err    (Underflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        wrong;
    logic [31:0] redir;
    logic [2:0]  cnt;
    logic        full;
    logic        uf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_id = 0;
  bit   drive_done = 1'b0;

  // Inputs for one cycle plus the outputs expected during that cycle
  // (Count/Full/Underflow_err reflect state before the closing edge).
  task automatic step(input logic [11:0] dop, input logic [31:0] dpc,
                      input logic [31:0] dtgt, input logic pred,
                      input logic [11:0] cop, input logic ctk,
                      input logic e_wrong, input logic [31:0] e_redir,
                      input logic [2:0] e_cnt, input logic e_full,
                      input logic e_uf);
    exp_t e;
    @(posedge clk);
    #1;
    Decoded_opcode = dop;
    Decoded_PC     = dpc;
    Decoded_target = dtgt;
    predicted      = pred;
    Commit_opcode  = cop;
    Commit_taken   = ctk;
    step_id++;
    e.id = step_id; e.wrong = e_wrong; e.redir = e_redir;
    e.cnt = e_cnt; e.full = e_full; e.uf = e_uf;
    sb.push_back(e);
  endtask

  task automatic idle(input logic [2:0] e_cnt, input logic e_full, input logic e_uf);
    step(NOP, 32'h0, 32'h0, 1'b0, NOP, 1'b0, 1'b0, 32'h0, e_cnt, e_full, e_uf);
  endtask

  task automatic set_rst(input logic v);
    @(negedge clk);
    #1 rst = v;
  endtask

  task automatic check1(input int id, input string nm, input logic [31:0] got,
                        input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL step%0d %s: got %0h want %0h", id, nm, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check1(e.id, "Wrong_prediction", 32'(Wrong_prediction), 32'(e.wrong));
        check1(e.id, "Redirect_PC",      Redirect_PC,           e.redir);
        check1(e.id, "Count",            32'(Count),            32'(e.cnt));
        check1(e.id, "Full",             32'(Full),             32'(e.full));
        check1(e.id, "Underflow_err",    32'(Underflow_err),    32'(e.uf));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin : driver
    // Reset with random inputs, including branch commits
    for (int i = 0; i < 3; i++)
      step($urandom_range(0, 1) ? OP_BEQ : OP_BNE, $urandom, $urandom, 1'($urandom),
           $urandom_range(0, 1) ? OP_BEQ : OP_BNE, 1'($urandom),
           1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    idle(3'd0, 1'b0, 1'b0);
    set_rst(1'b1);

    // Correct not-taken
    step(OP_BEQ, 32'h10, 32'h40, 1'b0, NOP, 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    idle(3'd1, 1'b0, 1'b0);
    step(NOP, 32'h0, 32'h0, 1'b0, OP_BEQ, 1'b0, 1'b0, 32'h0, 3'd1, 1'b0, 1'b0);
    idle(3'd0, 1'b0, 1'b0);

    // Mispredict squash; same-cycle push is discarded
    step(OP_BEQ, 32'h10, 32'h40, 1'b0, NOP, 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    step(OP_BNE, 32'h20, 32'h80, 1'b1, NOP, 1'b0, 1'b0, 32'h0, 3'd1, 1'b0, 1'b0);
    step(OP_BEQ, 32'h30, 32'h90, 1'b0, NOP, 1'b0, 1'b0, 32'h0, 3'd2, 1'b0, 1'b0);
    step(OP_BEQ, 32'h50, 32'h60, 1'b0, OP_BEQ, 1'b1, 1'b1, 32'h40, 3'd3, 1'b0, 1'b0);
    idle(3'd0, 1'b0, 1'b0);

    // Full handling and FIFO order across pointer wrap
    step(OP_BEQ, 32'h100, 32'h200, 1'b0, NOP, 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    step(OP_BNE, 32'h110, 32'h210, 1'b1, NOP, 1'b0, 1'b0, 32'h0, 3'd1, 1'b0, 1'b0);
    step(OP_BEQ, 32'h120, 32'h220, 1'b0, NOP, 1'b0, 1'b0, 32'h0, 3'd2, 1'b0, 1'b0);
    step(OP_BNE, 32'h130, 32'h230, 1'b1, NOP, 1'b0, 1'b0, 32'h0, 3'd3, 1'b0, 1'b0);
    idle(3'd4, 1'b1, 1'b0);
    step(OP_BEQ, 32'h140, 32'h999, 1'b0, NOP, 1'b0, 1'b0, 32'h0, 3'd4, 1'b1, 1'b0);
    idle(3'd4, 1'b1, 1'b0);
    step(OP_BEQ, 32'h150, 32'h250, 1'b1, OP_BEQ, 1'b0, 1'b0, 32'h0, 3'd4, 1'b1, 1'b0);
    idle(3'd4, 1'b1, 1'b0);
    step(NOP, 32'h0, 32'h0, 1'b0, OP_BNE, 1'b1, 1'b0, 32'h0, 3'd4, 1'b1, 1'b0);
    step(NOP, 32'h0, 32'h0, 1'b0, OP_BEQ, 1'b0, 1'b0, 32'h0, 3'd3, 1'b0, 1'b0);
    step(NOP, 32'h0, 32'h0, 1'b0, OP_BNE, 1'b1, 1'b0, 32'h0, 3'd2, 1'b0, 1'b0);
    step(NOP, 32'h0, 32'h0, 1'b0, OP_BEQ, 1'b0, 1'b1, 32'h151, 3'd1, 1'b0, 1'b0);
    idle(3'd0, 1'b0, 1'b0);

    // Underflow with a simultaneous push
    step(OP_BEQ, 32'h300, 32'h310, 1'b0, OP_BNE, 1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    idle(3'd1, 1'b0, 1'b1);
    idle(3'd1, 1'b0, 1'b1);
    step(NOP, 32'h0, 32'h0, 1'b0, OP_BEQ, 1'b0, 1'b0, 32'h0, 3'd1, 1'b0, 1'b1);
    idle(3'd0, 1'b0, 1'b1);

    // Predicted taken at the top of the PC space, resolved not taken
    step(OP_BNE, 32'hFFFF_FFFF, 32'h5, 1'b1, NOP, 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
    step(NOP, 32'h0, 32'h0, 1'b0, OP_BNE, 1'b0, 1'b1, 32'h0, 3'd1, 1'b0, 1'b1);
    idle(3'd0, 1'b0, 1'b1);

    // Mid-operation reset drops entries and clears the sticky error
    step(OP_BEQ, 32'h400, 32'h77, 1'b0, NOP, 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b1);
    idle(3'd1, 1'b0, 1'b1);
    set_rst(1'b0);
    step(NOP, 32'h0, 32'h0, 1'b0, OP_BEQ, 1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    idle(3'd0, 1'b0, 1'b0);
    set_rst(1'b1);
    step(OP_BEQ, 32'h500, 32'h580, 1'b0, NOP, 1'b0, 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    step(NOP, 32'h0, 32'h0, 1'b0, OP_BEQ, 1'b1, 1'b1, 32'h580, 3'd1, 1'b0, 1'b0);
    idle(3'd0, 1'b0, 1'b0);

    drive_done = 1'b1;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolution_queue.md
# branch_resolution_queue

Tracks every conditional branch (beq/bne) from decode to commit in the out-of-order core. At decode it captures the branch predictor's direction and the PC to use if that direction is wrong. At commit it compares the head entry with the actual outcome and drives `Wrong_prediction` to the branch predictor in the same cycle. On a misprediction it also supplies the fetch redirect PC and squashes all younger in-flight branch entries.

## Interface
Parameters:
- `DEPTH`, 4: number of in-flight branch entries; power of two, ≥2.
- `PC_W`, 32: PC width.
- `PC_STEP`, 1: sequential PC increment.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `Decoded_opcode`  in  12  opcode in decode, same encoding as `opcodes.txt`.
- `Decoded_PC`  in  PC_W  PC of the decoded instruction.
- `Decoded_target`  in  PC_W  taken-target computed at decode.
- `predicted`  in  1  predictor direction for the decoded instruction (1 = taken).
- `Commit_opcode`  in  12  opcode committing this cycle.
- `Commit_taken`  in  1  resolved direction of the committing branch.
- `Wrong_prediction`  out  1  committing branch was mispredicted; combinational.
- `Redirect_PC`  out  PC_W  correct fetch PC; valid when `Wrong_prediction`=1, 0 otherwise.
- `Full`  out  1  queue holds DEPTH entries; decode must stall branches.
- `Count`  out  $clog2(DEPTH)+1  current occupancy.
- `Underflow_err`  out  1  sticky: a branch committed while the queue was empty.

## Operation
- `is_br(op)` is defined as op == beq or op == bne.
- **Push** when `is_br(Decoded_opcode)`, and either not `Full` or a pop occurs in the same cycle.
  - Stored entry is {pred = `predicted`, alt_pc}.
  - alt_pc = `predicted` ? `Decoded_PC`+`PC_STEP` : `Decoded_target`, modulo 2^PC_W.
- A push attempted while `Full` with no simultaneous pop is dropped and the state is unchanged. Decode is required to stall in that case.
- **Pop** when `is_br(Commit_opcode)` and `Count`>0. Pop always removes the head entry; commit order equals decode order.
- **Mispredict:** on a pop with head.pred != `Commit_taken`:
  - `Wrong_prediction`=1 and `Redirect_PC`=head.alt_pc.
  - At the clock edge, head and tail pointers reset to 0 and `Count` goes to 0. A push in the same cycle is discarded because it is a younger, squashed branch.
- **Correct prediction:** `Wrong_prediction`=0, `Redirect_PC`=0, and the head advances.
- **Empty commit:** `is_br(Commit_opcode)` with `Count`=0 sets `Underflow_err`, which stays set until reset. `Wrong_prediction` stays 0 and pointers are unchanged. A same-cycle push still occurs.
- **Simultaneous push and pop without mispredict:** `Count` is unchanged and both pointers advance. This is legal when `Full`.
- **Pointer wrap:** head and tail are $clog2(DEPTH) bits and wrap modulo DEPTH. `Count` disambiguates full from empty.

## Timing
- `Wrong_prediction` and `Redirect_PC` are combinational from `Commit_opcode`, `Commit_taken` and the registered head entry, with zero latency. This matches the branch predictor, which samples `Wrong_prediction` on the same edge as `Commit_opcode`.
- `Full` and `Count` are registered-state outputs that change one edge after a push or pop.
- A pushed entry is visible at the head on the edge after the push, so back-to-back decode then commit of the same branch is legal one cycle apart.
- **Reset** (`rst`=0, asynchronous): pointers = 0, `Count`=0, `Full`=0, `Underflow_err`=0. While reset is held, `Wrong_prediction`=0 and `Redirect_PC`=0 regardless of inputs. Entry storage need not be cleared.
- If reset is asserted mid-operation, all in-flight entries are lost. The first edge after release behaves as from an empty queue.

## Structure
- Shared package `branch_pkg`:
  - beq/bne opcode constants (replacing the textual include for new code).
  - `is_br` function.
  - Entry struct {pred, alt_pc}.
- Sub-module `branch_entry_fifo`: parameterised DEPTH×(1+PC_W) storage with head/tail/count, ports push, pop, flush, full, count and head_data.
- The top level adds the opcode decode, alt_pc arithmetic, compare, redirect and error logic.

## Test plan
- **Reset:** reset with all inputs random → `Count`=0, `Full`=0, `Wrong_prediction`=0, `Redirect_PC`=0, `Underflow_err`=0.
- **Correct not-taken:** push beq with PC=0x10, target=0x40, predicted=0; commit beq with taken=0 → `Wrong_prediction`=0, `Count` goes 1→0.
- **Mispredict squash:** push three branches (predicted=0, PC=0x10, target=0x40 first); commit with taken=1 → `Wrong_prediction`=1, `Redirect_PC`=0x40, `Count`=0 next cycle. A same-cycle push is discarded.
- **Full handling (DEPTH=4):**
  - Push 4 → `Full`=1.
  - A 5th push alone is dropped, `Count`=4.
  - 5th push together with a correct commit → `Count` stays 4 and the entry is stored.
  - Drain four commits and check entries come out in FIFO order across the pointer wrap.
- **Underflow:** commit bne on an empty queue → `Underflow_err`=1 and it persists, `Wrong_prediction`=0; a simultaneous push gives `Count`=1.
- **Predicted taken, resolved not taken:** push with predicted=1, PC=0xFFFFFFFF; commit taken=0 → `Redirect_PC`=0x00000000 (wrap).
